// File: rtl/sfft_peak_pkg.sv
// Shared widths, FSM state type and peak-table entry for the SFFT peak finder.
package sfft_peak_pkg;

    localparam int unsigned BIN_ADDR_W = 8;
    localparam int unsigned MAG_W      = 17;

    // Right shift that maps a bin index onto its band index.
    function automatic int unsigned band_shift(input int unsigned n_bins,
                                               input int unsigned num_bands);
        return $clog2(n_bins / (2 * num_bands));
    endfunction

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_e;

    typedef struct packed {
        logic [BIN_ADDR_W-1:0] bin;
        logic [MAG_W-1:0]      mag;
    } peak_entry_t;

endpackage

// File: rtl/bin_magnitude.sv
// Combinational |re| + |im| of one packed {imag, real} SFFT bin word.
module bin_magnitude
    import sfft_peak_pkg::*;
(
    input  logic [31:0]      bin_word,
    output logic [MAG_W-1:0] mag
);

    logic [16:0] re_ext;
    logic [16:0] im_ext;
    logic [16:0] abs_re;
    logic [16:0] abs_im;

    // 17-bit operands so that |-32768| and the 65536 sum both fit.
    always_comb begin
        re_ext = {bin_word[15], bin_word[15:0]};
        im_ext = {bin_word[31], bin_word[31:16]};
        abs_re = re_ext[16] ? (~re_ext + 17'd1) : re_ext;
        abs_im = im_ext[16] ? (~im_ext + 17'd1) : im_ext;
        mag    = MAG_W'(abs_re + abs_im);
    end

endmodule

// File: rtl/sfft_peak_finder.sv
// Per-band peak search over the lower half-spectrum with a double-buffered result table.
// Optional build macro PEAK_THRESHOLD_EN adds mag_threshold to suppress weak bins.
module sfft_peak_finder
    import sfft_peak_pkg::*;
#(
    parameter int unsigned N_BINS     = 256,
    parameter int unsigned BIN_ADDR_W = 8,
    parameter int unsigned NUM_BANDS  = 8,
    parameter int unsigned MAG_W      = 17
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_valid,
    output logic                         bin_rd,
    output logic [BIN_ADDR_W-1:0]        bin_addr,
    input  logic [31:0]                  bin_data,
    output logic                         reading_out,
    input  logic                         hold,
    input  logic [$clog2(NUM_BANDS)-1:0] rd_band,
    output logic [BIN_ADDR_W-1:0]        rd_peak_bin,
    output logic [MAG_W-1:0]             rd_peak_mag,
    output logic [31:0]                  table_frame,
    output logic                         table_valid,
    output logic                         overrun,
`ifdef PEAK_THRESHOLD_EN
    input  logic [MAG_W-1:0]             mag_threshold,
`endif
    input  logic                         clear_overrun
);

    localparam int unsigned           BAND_W     = $clog2(NUM_BANDS);
    localparam int unsigned           BAND_SHIFT = band_shift(N_BINS, NUM_BANDS);
    localparam logic [BIN_ADDR_W-1:0] LAST_ADDR  = BIN_ADDR_W'(N_BINS / 2 - 1);

    state_e                state_q, state_d;
    logic                  frame_q;
    logic                  frame_rise;
    logic [BIN_ADDR_W-1:0] addr_q, addr_d;
    logic                  rd_q;
    logic [BIN_ADDR_W-1:0] rd_addr_q;
    logic                  publish;
    logic [MAG_W-1:0]      raw_mag;
    logic [MAG_W-1:0]      bin_mag;
    logic [BAND_W-1:0]     band;

    peak_entry_t work_q [NUM_BANDS];
    peak_entry_t work_d [NUM_BANDS];
    peak_entry_t pub_q  [NUM_BANDS];

    assign frame_rise  = frame_valid & ~frame_q;
    assign bin_rd      = (state_q == SCAN);
    assign bin_addr    = addr_q;
    assign reading_out = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        publish = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_rise) state_d = SCAN;
            end
            SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: state_d = COMMIT;
            COMMIT: begin
                if (!hold) begin
                    publish = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    bin_magnitude u_bin_magnitude (
        .bin_word (bin_data),
        .mag      (raw_mag)
    );

    // rd_addr_q tags the datum returning this cycle; DC never competes.
    always_comb begin
        bin_mag = (rd_addr_q == '0) ? '0 : raw_mag;
`ifdef PEAK_THRESHOLD_EN
        if (bin_mag < mag_threshold) bin_mag = '0;
`endif
        band = BAND_W'(rd_addr_q >> BAND_SHIFT);
    end

    // Strictly-greater update keeps the lowest bin on ties.
    always_comb begin
        work_d = work_q;
        if (state_q == IDLE && frame_rise) begin
            for (int i = 0; i < NUM_BANDS; i++) work_d[i] = '0;
        end else if (rd_q && (bin_mag > work_q[band].mag)) begin
            work_d[band] = peak_entry_t'{bin: rd_addr_q, mag: bin_mag};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            frame_q     <= 1'b0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            rd_addr_q   <= '0;
            table_frame <= '0;
            table_valid <= 1'b0;
            overrun     <= 1'b0;
            rd_peak_bin <= '0;
            rd_peak_mag <= '0;
            for (int i = 0; i < NUM_BANDS; i++) begin
                work_q[i] <= '0;
                pub_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_valid;
            addr_q    <= addr_d;
            rd_q      <= bin_rd;
            rd_addr_q <= addr_q;
            for (int i = 0; i < NUM_BANDS; i++) work_q[i] <= work_d[i];
            if (publish) begin
                for (int i = 0; i < NUM_BANDS; i++) pub_q[i] <= work_q[i];
                table_frame <= table_frame + 32'd1;
                table_valid <= 1'b1;
            end
            // A frame edge while busy wins over a same-cycle clear.
            if (frame_rise && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
            rd_peak_bin <= pub_q[rd_band].bin;
            rd_peak_mag <= pub_q[rd_band].mag;
        end
    end

endmodule

// File: tb/tb_sfft_peak_finder.sv
// Directed self-checking bench for sfft_peak_finder with a behavioural SFFT output RAM.
module tb_sfft_peak_finder;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_valid;
    logic        bin_rd;
    logic [7:0]  bin_addr;
    logic [31:0] bin_data;
    logic        reading_out;
    logic        hold;
    logic [2:0]  rd_band;
    logic [7:0]  rd_peak_bin;
    logic [16:0] rd_peak_mag;
    logic [31:0] table_frame;
    logic        table_valid;
    logic        overrun;
    logic        clear_overrun;
`ifdef PEAK_THRESHOLD_EN
    logic [16:0] mag_threshold;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bin_rd) bin_data <= ram[bin_addr];
    end

    sfft_peak_finder dut (
        .clk           (clk),
        .reset         (reset),
        .frame_valid   (frame_valid),
        .bin_rd        (bin_rd),
        .bin_addr      (bin_addr),
        .bin_data      (bin_data),
        .reading_out   (reading_out),
        .hold          (hold),
        .rd_band       (rd_band),
        .rd_peak_bin   (rd_peak_bin),
        .rd_peak_mag   (rd_peak_mag),
        .table_frame   (table_frame),
        .table_valid   (table_valid),
        .overrun       (overrun),
`ifdef PEAK_THRESHOLD_EN
        .mag_threshold (mag_threshold),
`endif
        .clear_overrun (clear_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    endtask

    // Pulses a frame edge and follows the scan until reading_out drops (bounded).
    task automatic run_frame(output int ro_cyc, output int rd_cyc, output int addr_err);
        ro_cyc   = 0;
        rd_cyc   = 0;
        addr_err = 0;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int n = 0; n < 400 && reading_out; n++) begin
            ro_cyc++;
            if (bin_rd) begin
                if (bin_addr !== rd_cyc[7:0]) addr_err++;
                rd_cyc++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        checks++; if (bin_rd !== 1'b0) begin failures++; $display("FAIL reset_bin_rd: got %0b expected 0", bin_rd); end
        checks++; if (bin_addr !== 8'h0) begin failures++; $display("FAIL reset_bin_addr: got %0h expected 0", bin_addr); end
        checks++; if (reading_out !== 1'b0) begin failures++; $display("FAIL reset_reading_out: got %0b expected 0", reading_out); end
        checks++; if (rd_peak_bin !== 8'h0) begin failures++; $display("FAIL reset_rd_peak_bin: got %0h expected 0", rd_peak_bin); end
        checks++; if (rd_peak_mag !== 17'h0) begin failures++; $display("FAIL reset_rd_peak_mag: got %0h expected 0", rd_peak_mag); end
        checks++; if (table_frame !== 32'h0) begin failures++; $display("FAIL reset_table_frame: got %0h expected 0", table_frame); end
        checks++; if (table_valid !== 1'b0) begin failures++; $display("FAIL reset_table_valid: got %0b expected 0", table_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    endtask

    task automatic test_single_tone(input logic [31:0] exp_frame);
        int ro, rd, aerr;
        logic [7:0]  exp_bin;
        logic [16:0] exp_mag;
        clear_ram();
        ram[37] = 32'h0000_1000;
        hold = 1'b0;
        run_frame(ro, rd, aerr);
        checks++; if (ro != 130) begin failures++; $display("FAIL tone_reading_out_cycles: got %0d expected 130", ro); end
        checks++; if (rd != 128) begin failures++; $display("FAIL tone_bin_rd_cycles: got %0d expected 128", rd); end
        checks++; if (aerr != 0) begin failures++; $display("FAIL tone_addr_sequence: got %0d bad addresses expected 0", aerr); end
        checks++; if (table_frame !== exp_frame) begin failures++; $display("FAIL tone_table_frame: got %0d expected %0d", table_frame, exp_frame); end
        checks++; if (table_valid !== 1'b1) begin failures++; $display("FAIL tone_table_valid: got %0b expected 1", table_valid); end
        for (int b = 0; b < 8; b++) begin
            rd_band = 3'(b);
            tick();
            exp_bin = (b == 2) ? 8'd37 : 8'd0;
            exp_mag = (b == 2) ? 17'h01000 : 17'h0;
            checks++; if (rd_peak_bin !== exp_bin) begin failures++; $display("FAIL tone_band%0d_bin: got %0d expected %0d", b, rd_peak_bin, exp_bin); end
            checks++; if (rd_peak_mag !== exp_mag) begin failures++; $display("FAIL tone_band%0d_mag: got %0h expected %0h", b, rd_peak_mag, exp_mag); end
        end
    endtask

    task automatic test_tie();
        int ro, rd, aerr;
        clear_ram();
        ram[0]  = 32'h7FFF_7FFF;
        ram[20] = 32'h0000_8000;
        ram[21] = 32'h0000_8000;
        run_frame(ro, rd, aerr);
        checks++; if (table_frame !== 32'd2) begin failures++; $display("FAIL tie_table_frame: got %0d expected 2", table_frame); end
        rd_band = 3'd1;
        tick();
        checks++; if (rd_peak_bin !== 8'd20) begin failures++; $display("FAIL tie_band1_bin: got %0d expected 20", rd_peak_bin); end
        checks++; if (rd_peak_mag !== 17'h08000) begin failures++; $display("FAIL tie_band1_mag: got %0h expected 8000", rd_peak_mag); end
        rd_band = 3'd0;
        tick();
        checks++; if (rd_peak_bin !== 8'd0 || rd_peak_mag !== 17'h0) begin failures++; $display("FAIL tie_dc_forced: got bin %0d mag %0h expected bin 0 mag 0", rd_peak_bin, rd_peak_mag); end
        rd_band = 3'd2;
        tick();
        checks++; if (rd_peak_bin !== 8'd0 || rd_peak_mag !== 17'h0) begin failures++; $display("FAIL tie_band2_cleared: got bin %0d mag %0h expected bin 0 mag 0", rd_peak_bin, rd_peak_mag); end
    endtask

    task automatic test_hold();
        int changed;
        clear_ram();
        ram[100] = 32'h0010_0000;
        ram[101] = 32'hFFF0_0003;
        hold    = 1'b1;
        rd_band = 3'd6;
        changed = 0;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int n = 0; n < 128; n++) tick();
        checks++; if (bin_rd !== 1'b0 || reading_out !== 1'b1) begin failures++; $display("FAIL hold_drain_state: got bin_rd %0b reading_out %0b expected 0 1", bin_rd, reading_out); end
        for (int n = 0; n < 50; n++) begin
            if (table_frame !== 32'd2) changed++;
            tick();
        end
        checks++; if (changed != 0) begin failures++; $display("FAIL hold_frame_stable: got %0d changed cycles expected 0", changed); end
        checks++; if (table_frame !== 32'd2) begin failures++; $display("FAIL hold_frame_before_release: got %0d expected 2", table_frame); end
        checks++; if (rd_peak_mag !== 17'h0) begin failures++; $display("FAIL hold_table_before_release: got %0h expected 0", rd_peak_mag); end
        checks++; if (reading_out !== 1'b1) begin failures++; $display("FAIL hold_in_commit: got %0b expected 1", reading_out); end
        hold = 1'b0;
        tick();
        checks++; if (table_frame !== 32'd3) begin failures++; $display("FAIL hold_frame_after_release: got %0d expected 3", table_frame); end
        checks++; if (reading_out !== 1'b0) begin failures++; $display("FAIL hold_idle_after_release: got %0b expected 0", reading_out); end
        tick();
        checks++; if (rd_peak_bin !== 8'd101) begin failures++; $display("FAIL hold_band6_bin: got %0d expected 101", rd_peak_bin); end
        checks++; if (rd_peak_mag !== 17'h00013) begin failures++; $display("FAIL hold_band6_mag: got %0h expected 13", rd_peak_mag); end
    endtask

    task automatic test_overrun();
        int busy;
        // Second edge sampled 10 cycles into the scan.
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %0b expected 1", overrun); end
        for (int n = 0; n < 300 && reading_out; n++) tick();
        checks++; if (reading_out !== 1'b0) begin failures++; $display("FAIL overrun_scan_timeout: got %0b expected 0", reading_out); end
        busy = 0;
        for (int n = 0; n < 5; n++) begin
            if (reading_out !== 1'b0) busy++;
            tick();
        end
        checks++; if (busy != 0) begin failures++; $display("FAIL overrun_no_second_scan: got %0d busy cycles expected 0", busy); end
        checks++; if (table_frame !== 32'd4) begin failures++; $display("FAIL overrun_one_publish: got %0d expected 4", table_frame); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %0b expected 1", overrun); end
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %0b expected 0", overrun); end
        // Same-cycle set and clear.
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        frame_valid   = 1'b1;
        clear_overrun = 1'b1;
        tick();
        frame_valid   = 1'b0;
        clear_overrun = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set_wins: got %0b expected 1", overrun); end
        for (int n = 0; n < 300 && reading_out; n++) tick();
        checks++; if (table_frame !== 32'd5) begin failures++; $display("FAIL overrun_second_publish: got %0d expected 5", table_frame); end
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int ro, rd, aerr;
        rd_band = 3'd6;
        tick();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        for (int n = 0; n < 59; n++) tick();
        checks++; if (rd_peak_bin !== 8'd101) begin failures++; $display("FAIL midreset_pre_bin: got %0d expected 101", rd_peak_bin); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bin_rd !== 1'b0) begin failures++; $display("FAIL midreset_bin_rd: got %0b expected 0", bin_rd); end
        checks++; if (bin_addr !== 8'h0) begin failures++; $display("FAIL midreset_bin_addr: got %0h expected 0", bin_addr); end
        checks++; if (reading_out !== 1'b0) begin failures++; $display("FAIL midreset_reading_out: got %0b expected 0", reading_out); end
        checks++; if (rd_peak_bin !== 8'h0 || rd_peak_mag !== 17'h0) begin failures++; $display("FAIL midreset_rd_peak: got bin %0d mag %0h expected 0 0", rd_peak_bin, rd_peak_mag); end
        checks++; if (table_frame !== 32'h0 || table_valid !== 1'b0) begin failures++; $display("FAIL midreset_table: got frame %0d valid %0b expected 0 0", table_frame, table_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midreset_overrun: got %0b expected 0", overrun); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        rd_band = 3'd6;
        tick();
        checks++; if (rd_peak_mag !== 17'h0) begin failures++; $display("FAIL midreset_table_zero: got %0h expected 0", rd_peak_mag); end
        test_single_tone(32'd1);
    endtask

`ifdef PEAK_THRESHOLD_EN
    task automatic test_threshold();
        int ro, rd, aerr;
        clear_ram();
        ram[50] = 32'h0000_00FF;
        ram[70] = 32'h0000_0100;
        mag_threshold = 17'h00100;
        run_frame(ro, rd, aerr);
        rd_band = 3'd3;
        tick();
        checks++; if (rd_peak_bin !== 8'd0 || rd_peak_mag !== 17'h0) begin failures++; $display("FAIL thr_band3: got bin %0d mag %0h expected 0 0", rd_peak_bin, rd_peak_mag); end
        rd_band = 3'd4;
        tick();
        checks++; if (rd_peak_bin !== 8'd70 || rd_peak_mag !== 17'h00100) begin failures++; $display("FAIL thr_band4: got bin %0d mag %0h expected 70 100", rd_peak_bin, rd_peak_mag); end
        mag_threshold = 17'h0;
    endtask
`endif

    initial begin
        reset         = 1'b0;
        frame_valid   = 1'b0;
        hold          = 1'b0;
        rd_band       = 3'd0;
        clear_overrun = 1'b0;
        bin_data      = 32'h0;
`ifdef PEAK_THRESHOLD_EN
        mag_threshold = 17'h0;
`endif
        clear_ram();
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_single_tone(32'd1);
        test_tie();
        test_hold();
        test_overrun();
        test_reset_mid_scan();
`ifdef PEAK_THRESHOLD_EN
        test_threshold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sfft_peak_finder.md
# sfft_peak_finder

Downstream stage of the SFFT pipeline. On each new SFFT frame it scans the lower half-spectrum out of the SFFT output RAM and finds the strongest bin in each of NUM_BANDS equal-width frequency bands. It publishes the result as a double-buffered peak table, with a frame stamp, to the software read interface. While scanning it asserts the output-read lock so the pipeline does not overwrite the frame mid-scan.

## Interface
Parameters:
- N_BINS, 256 — FFT length; bins 0..N_BINS/2-1 are scanned
- BIN_ADDR_W, 8 — log2(N_BINS)
- NUM_BANDS, 8 — power of two; must divide N_BINS/2
- MAG_W, 17 — magnitude width

Ports:
- clk  in  1  — single system clock
- reset  in  1  — asynchronous, active-low reset
- frame_valid  in  1  — SFFT output-valid level; a rising edge starts a scan
- bin_rd  out  1  — read strobe to the SFFT output RAM
- bin_addr  out  BIN_ADDR_W  — bin address
- bin_data  in  32  — {imag[15:0], real[15:0]}, signed two's complement; valid on the cycle after bin_rd
- reading_out  out  1  — high whenever the FSM is not IDLE; feeds the pipeline's output-being-read input
- hold  in  1  — software is reading the table; blocks publish
- rd_band  in  log2(NUM_BANDS)  — table read select
- rd_peak_bin  out  BIN_ADDR_W  — published peak bin for rd_band
- rd_peak_mag  out  MAG_W  — published peak magnitude for rd_band
- table_frame  out  32  — count of published tables
- table_valid  out  1  — at least one table has been published
- overrun  out  1  — sticky; a frame edge arrived while busy
- clear_overrun  in  1  — synchronous clear of overrun

## Operation
- Magnitude: |re| + |im|, unsigned MAG_W bits. |−32768| = 32768. No saturation is needed, since the maximum is 65536.
- Band mapping: band = bin >> log2(N_BINS/(2·NUM_BANDS)). Bin 0 (DC) is forced to magnitude 0.
- FSM states and transitions:
  - IDLE → SCAN on a frame_valid rising edge. The edge detector is a registered copy of frame_valid, reset to 0.
  - SCAN: clear the working table at entry. Issue addresses 0..N_BINS/2−1, one per cycle, with bin_rd=1.
  - SCAN → DRAIN after the last address is issued.
  - DRAIN: consume the final read datum; go to COMMIT.
  - COMMIT: if hold==0, copy working→published, increment table_frame, set table_valid, then go to IDLE. If hold==1, stay in COMMIT.
- Compare rule: the working entry is updated only if the incoming mag is strictly greater than the stored mag. Ties therefore keep the lowest bin. A band with all zero magnitudes reports bin 0, mag 0.
- Frame rising edge in any state other than IDLE: overrun←1 and the frame is ignored.
- If clear_overrun and a new overrun occur in the same cycle, set wins.
- table_frame wraps from 0xFFFFFFFF to 0.
- Readout: rd_peak_bin and rd_peak_mag are registered from the published table, with 1-cycle latency from rd_band.

## Timing
- Reset values: bin_rd=0, bin_addr=0, reading_out=0, rd_peak_bin=0, rd_peak_mag=0, table_frame=0, table_valid=0, overrun=0. FSM=IDLE, both tables all zero.
- Reset mid-scan aborts the scan. Published contents return to zero; nothing partial is published.
- Sequence from a frame edge sampled at edge E (N_BINS=256):
  - bin_rd is high for cycles E+1..E+128; data for address k is used in cycle E+2+k.
  - DRAIN is cycle E+129; COMMIT is cycle E+130.
  - With hold=0, the new table and table_frame are visible from cycle E+131.
  - reading_out is high for E+1 through the COMMIT exit.
- Hold: hold rising during SCAN does not stall the scan; it only delays the commit. Publish occurs on the first COMMIT cycle with hold==0.
- Minimum frame spacing without overrun: N_BINS/2+3 cycles.

## Configuration
- PEAK_THRESHOLD_EN defined:
  - Adds input port mag_threshold [MAG_W-1:0].
  - Bins with mag < mag_threshold are treated as mag 0.
  - A band with no qualifying bin reports bin 0, mag 0.
- PEAK_THRESHOLD_EN undefined: no port is added, and every bin participates.

## Structure
- Package sfft_peak_pkg holds:
  - the width constants (BIN_ADDR_W, MAG_W, the band-shift derivation);
  - the FSM state enum {IDLE, SCAN, DRAIN, COMMIT};
  - the peak_entry_t struct {bin, mag}.
- Sub-module bin_magnitude: purely combinational, 32-bit bin word → MAG_W magnitude (abs-sum, DC forcing done by the caller). All other logic lives in sfft_peak_finder.

## Test plan
- Single tone:
  - Stimulus: RAM with bin 37 = {0x0000, 0x1000} and all other bins 0; pulse a frame with hold=0.
  - Response: band 2 reads bin 37, mag 0x01000; all other bands read bin 0, mag 0; table_frame=1; reading_out high for exactly 130 cycles.
- Tie and negative extreme:
  - Stimulus: bins 20 and 21 = {0x0000, 0x8000}.
  - Response: band 1 reports bin 20, mag 0x08000.
- Hold:
  - Stimulus: hold=1 throughout the scan, released 50 cycles after DRAIN.
  - Response: the published table and table_frame are unchanged until the cycle after release.
- Overrun:
  - Stimulus: a second frame edge 10 cycles into a scan.
  - Response: overrun=1, only one table published; clear_overrun drops overrun the next cycle.
- Reset mid-scan:
  - Stimulus: assert reset at scan cycle 60.
  - Response: all outputs are zero asynchronously; after release, a new frame produces table_frame=1.
- Threshold (PEAK_THRESHOLD_EN defined):
  - Stimulus: mag_threshold=0x00100; a bin with mag 0x000FF.
  - Response: that band reports bin 0, mag 0.
